// File: rtl/vx_branch_commit.sv
// vx_branch_commit
//   Collects branch resolutions from every integer ALU block, buffers them in
//   one small FIFO per block, and serializes them round-robin into a single
//   registered commit stream for the warp scheduler. It also keeps a per-warp
//   mask of branches that have issued but not yet resolved.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-low reset
//   br_valid       per-block resolution strobe (no back-pressure)
//   br_wid         per-block warp id, packed NUM_BLOCKS x NW_WIDTH
//   br_taken       per-block taken flag
//   br_dest        per-block target PC, packed NUM_BLOCKS x PC_BITS
//   issue_valid    scheduler issued a branch for issue_wid
//   issue_wid      warp that issued the branch
//   commit_valid   registered commit strobe, one cycle per resolution
//   commit_wid     warp being resolved
//   commit_taken   redirect required
//   commit_dest    redirect target (meaningful when commit_taken=1)
//   pending        per-warp unresolved-branch mask
//   overflow_err   sticky: a block FIFO dropped an entry
//   spurious_err   sticky: a commit arrived for a warp that was not pending
module vx_branch_commit #(
  parameter int NUM_BLOCKS = 2,
  parameter int NUM_WARPS  = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int PC_BITS    = 32,
  localparam int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BLOCKS-1:0]          br_valid,
  input  logic [NUM_BLOCKS*NW_WIDTH-1:0] br_wid,
  input  logic [NUM_BLOCKS-1:0]          br_taken,
  input  logic [NUM_BLOCKS*PC_BITS-1:0]  br_dest,
  input  logic                           issue_valid,
  input  logic [NW_WIDTH-1:0]            issue_wid,
  output logic                           commit_valid,
  output logic [NW_WIDTH-1:0]            commit_wid,
  output logic                           commit_taken,
  output logic [PC_BITS-1:0]             commit_dest,
  output logic [NUM_WARPS-1:0]           pending,
  output logic                           overflow_err,
  output logic                           spurious_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  // Per-block storage
  logic [NW_WIDTH-1:0] mem_wid   [NUM_BLOCKS][FIFO_DEPTH];
  logic                mem_taken [NUM_BLOCKS][FIFO_DEPTH];
  logic [PC_BITS-1:0]  mem_dest  [NUM_BLOCKS][FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr [NUM_BLOCKS];
  logic [PTR_W-1:0] rd_ptr [NUM_BLOCKS];
  logic [CNT_W-1:0] count  [NUM_BLOCKS];

  logic [BLK_W-1:0] rr_ptr;

  // Arbitration / datapath
  logic                  grant_any;
  logic [BLK_W-1:0]      grant_idx;
  logic [NUM_BLOCKS-1:0] pop_vec;
  logic [NUM_BLOCKS-1:0] push_ok;
  logic [NW_WIDTH-1:0]   pop_wid;
  logic                  pop_taken;
  logic [PC_BITS-1:0]    pop_dest;
  logic [NUM_WARPS-1:0]  set_vec;
  logic [NUM_WARPS-1:0]  clr_vec;
  logic [NUM_WARPS-1:0]  pending_nxt;
  logic                  drop_any;
  logic                  spurious_hit;

  // Round-robin: first scan blocks rr_ptr..N-1, then 0..rr_ptr-1; the first
  // non-empty block found wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      if (!grant_any && (b >= 32'(rr_ptr)) && (count[b] != '0)) begin
        grant_any = 1'b1;
        grant_idx = BLK_W'(b);
      end
    end
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      if (!grant_any && (b < 32'(rr_ptr)) && (count[b] != '0)) begin
        grant_any = 1'b1;
        grant_idx = BLK_W'(b);
      end
    end
  end

  always_comb begin
    pop_vec  = '0;
    push_ok  = '0;
    drop_any = 1'b0;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      pop_vec[b] = grant_any && (grant_idx == BLK_W'(b));
      // A full FIFO that is being popped this cycle still has room.
      push_ok[b] = br_valid[b] && ((count[b] != CNT_W'(FIFO_DEPTH)) || pop_vec[b]);
      if (br_valid[b] && !push_ok[b]) drop_any = 1'b1;
    end
  end

  always_comb begin
    pop_wid   = mem_wid[grant_idx][rd_ptr[grant_idx]];
    pop_taken = mem_taken[grant_idx][rd_ptr[grant_idx]];
    pop_dest  = mem_dest[grant_idx][rd_ptr[grant_idx]];
  end

  // Set wins over clear when issue and resolution hit the same warp.
  always_comb begin
    set_vec      = issue_valid ? (NUM_WARPS'(1) << issue_wid) : '0;
    clr_vec      = grant_any ? (NUM_WARPS'(1) << pop_wid) : '0;
    pending_nxt  = (pending & ~clr_vec) | set_vec;
    spurious_hit = grant_any && !pending[pop_wid] &&
                   !(issue_valid && (issue_wid == pop_wid));
  end

  // FIFO storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      if (push_ok[b]) begin
        mem_wid[b][wr_ptr[b]]   <= br_wid[b*NW_WIDTH +: NW_WIDTH];
        mem_taken[b][wr_ptr[b]] <= br_taken[b];
        mem_dest[b][wr_ptr[b]]  <= br_dest[b*PC_BITS +: PC_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        wr_ptr[b] <= '0;
        rd_ptr[b] <= '0;
        count[b]  <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        if (push_ok[b]) wr_ptr[b] <= wr_ptr[b] + PTR_W'(1);
        if (pop_vec[b]) rd_ptr[b] <= rd_ptr[b] + PTR_W'(1);
        count[b] <= count[b] + CNT_W'(push_ok[b]) - CNT_W'(pop_vec[b]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      commit_valid <= 1'b0;
      commit_wid   <= '0;
      commit_taken <= 1'b0;
      commit_dest  <= '0;
      pending      <= '0;
      overflow_err <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      commit_valid <= grant_any;
      if (grant_any) begin
        commit_wid   <= pop_wid;
        commit_taken <= pop_taken;
        commit_dest  <= pop_dest;
        rr_ptr       <= (grant_idx == BLK_W'(NUM_BLOCKS - 1)) ? '0 : grant_idx + BLK_W'(1);
      end
      pending <= pending_nxt;
      if (drop_any)     overflow_err <= 1'b1;
      if (spurious_hit) spurious_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_branch_commit.sv
module tb_vx_branch_commit;

  localparam int NB    = 3;
  localparam int NW    = 8;
  localparam int DEPTH = 2;
  localparam int PCB   = 32;
  localparam int NWW   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NB-1:0]     br_valid;
  logic [NB*NWW-1:0] br_wid;
  logic [NB-1:0]     br_taken;
  logic [NB*PCB-1:0] br_dest;
  logic              issue_valid;
  logic [NWW-1:0]    issue_wid;
  logic              commit_valid;
  logic [NWW-1:0]    commit_wid;
  logic              commit_taken;
  logic [PCB-1:0]    commit_dest;
  logic [NW-1:0]     pending;
  logic              overflow_err;
  logic              spurious_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vx_branch_commit #(
    .NUM_BLOCKS (NB),
    .NUM_WARPS  (NW),
    .FIFO_DEPTH (DEPTH),
    .PC_BITS    (PCB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .br_valid     (br_valid),
    .br_wid       (br_wid),
    .br_taken     (br_taken),
    .br_dest      (br_dest),
    .issue_valid  (issue_valid),
    .issue_wid    (issue_wid),
    .commit_valid (commit_valid),
    .commit_wid   (commit_wid),
    .commit_taken (commit_taken),
    .commit_dest  (commit_dest),
    .pending      (pending),
    .overflow_err (overflow_err),
    .spurious_err (spurious_err)
  );

  // Reference model: one queue per block, integer round-robin pointer.
  typedef struct {
    int       wid;
    bit       taken;
    bit [31:0] dest;
  } ent_t;

  ent_t      q [NB][$];
  int        rr;
  bit        m_cv;
  int        m_wid;
  bit        m_taken;
  bit [31:0] m_dest;
  bit [NW-1:0] m_pend;
  bit        m_ovf;
  bit        m_spur;

  task automatic model_reset();
    for (int b = 0; b < NB; b++) q[b].delete();
    rr = 0; m_cv = 0; m_wid = 0; m_taken = 0; m_dest = 0;
    m_pend = '0; m_ovf = 0; m_spur = 0;
  endtask

  task automatic model_step();
    int   g;
    ent_t e;
    g = -1;
    for (int i = 0; i < NB; i++) begin
      int k;
      k = (rr + i) % NB;
      if (g < 0 && q[k].size() > 0) g = k;
    end
    if (g >= 0) begin
      e = q[g].pop_front();
      m_cv = 1; m_wid = e.wid; m_taken = e.taken; m_dest = e.dest;
      if (!m_pend[e.wid] && !(issue_valid && int'(issue_wid) == e.wid)) m_spur = 1;
      m_pend[e.wid] = 0;
      rr = (g + 1) % NB;
    end else begin
      m_cv = 0;
    end
    if (issue_valid) m_pend[issue_wid] = 1;
    for (int b = 0; b < NB; b++) begin
      if (br_valid[b]) begin
        if (q[b].size() < DEPTH) begin
          e.wid   = int'(br_wid[b*NWW +: NWW]);
          e.taken = br_taken[b];
          e.dest  = br_dest[b*PCB +: PCB];
          q[b].push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("commit_valid", 64'(commit_valid), 64'(m_cv));
    chk("commit_wid",   64'(commit_wid),   64'(m_wid));
    chk("commit_taken", 64'(commit_taken), 64'(m_taken));
    chk("commit_dest",  64'(commit_dest),  64'(m_dest));
    chk("pending",      64'(pending),      64'(m_pend));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("spurious_err", 64'(spurious_err), 64'(m_spur));
  endtask

  task automatic fire(input int b, input int wid, input bit taken, input bit [31:0] dest);
    br_valid[b]          = 1'b1;
    br_wid[b*NWW +: NWW] = NWW'(wid);
    br_taken[b]          = taken;
    br_dest[b*PCB +: PCB] = dest;
  endtask

  task automatic issue(input int wid);
    issue_valid = 1'b1;
    issue_wid   = NWW'(wid);
  endtask

  // One clock: model consumes the driven inputs, DUT is sampled 1 time unit
  // after the edge, then inputs return to idle.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    br_valid    = '0;
    issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    br_valid = '0; br_wid = '0; br_taken = '0; br_dest = '0;
    issue_valid = 1'b0; issue_wid = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single resolution
    issue(3);
    cycle();
    chk("single_pend3_set", 64'(pending[3]), 64'd1);
    repeat (3) cycle();
    fire(0, 3, 1'b1, 32'h4010);
    cycle();
    cycle();
    chk("single_cv", 64'(commit_valid), 64'd1);
    chk("single_wid", 64'(commit_wid), 64'd3);
    chk("single_taken", 64'(commit_taken), 64'd1);
    chk("single_dest", 64'(commit_dest), 64'h4010);
    chk("single_pend3_clr", 64'(pending[3]), 64'd0);
    chk("single_no_err", 64'({overflow_err, spurious_err}), 64'd0);

    // Simultaneous clear and set on warp 5
    issue(5);
    cycle();
    fire(1, 5, 1'b0, 32'h0100);
    cycle();
    issue(5);
    cycle();
    chk("setclr_cv", 64'(commit_valid), 64'd1);
    chk("setclr_pend5", 64'(pending[5]), 64'd1);
    chk("setclr_no_spur", 64'(spurious_err), 64'd0);

    // Round robin: two blocks firing on two consecutive cycles
    for (int w = 0; w < 4; w++) begin
      issue(w);
      cycle();
    end
    fire(0, 0, 1'b1, 32'h1000); fire(1, 1, 1'b0, 32'h1100);
    cycle();
    fire(0, 2, 1'b1, 32'h1200); fire(1, 3, 1'b1, 32'h1300);
    cycle();
    repeat (5) cycle();

    // Spurious commit for a warp never issued
    fire(2, 7, 1'b1, 32'h7770);
    cycle();
    cycle();
    chk("spur_cv", 64'(commit_valid), 64'd1);
    chk("spur_wid", 64'(commit_wid), 64'd7);
    chk("spur_flag", 64'(spurious_err), 64'd1);

    // Overflow: every block fires three cycles in a row
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < NB; b++) fire(b, b + c, 1'b1, 32'(16 * c + b));
      cycle();
    end
    chk("ovf_flag", 64'(overflow_err), 64'd1);
    repeat (8) cycle();
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // Reset with entries buffered and pending = 0x0F
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int w = 0; w < 4; w++) begin
      issue(w);
      cycle();
    end
    for (int b = 0; b < NB; b++) fire(b, b, 1'b1, 32'(32'h2000 + b));
    cycle();
    chk("mid_pending", 64'(pending), 64'h0F);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_cv", 64'(commit_valid), 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
      end
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(99) < ((n < 1500) ? 20 : 40))
          fire(b, int'($urandom_range(NW - 1)), 1'($urandom), $urandom);
      end
      if ($urandom_range(1)) issue(int'($urandom_range(NW - 1)));
      cycle();
    end
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
